eth_rmii_tx: RTL and testbench
==============================

Name: eth_rmii_tx

Overview:
- Transmit-side counterpart of the firewall's 2-bit receive path.
- Accepts a frame as a byte stream (destination address, source address, length/type, payload) and emits it on a 2-bit dibit bus matching the firewall input: valid plus dibit, one dibit per clk.
- Generates the preamble and SFD, pads short frames, appends the Ethernet FCS (CRC-32) and enforces the inter-frame gap.
- Feeds the firewall in loopback and drives the PHY TX pins.

Parameters:
PREAMBLE_BYTES, 7, count of 0x55 bytes before SFD
MIN_FRAME_BYTES, 60, minimum DA..payload byte count before FCS; shorter frames zero-padded
MAX_FRAME_BYTES, 1514, maximum DA..payload byte count; exceeding it aborts the frame
IFG_BYTES, 12, idle byte-times after FCS before next frame may start

Ports:
clk  in  1  system clock, one dibit per cycle
rst_n  in  1  asynchronous active-low reset
axiiv  in  1  input byte valid; in IDLE also the frame-start request
axiid  in  8  input byte
axiilast  in  1  qualifies final frame byte (sampled with handshake)
axiiready  out  1  byte accepted when axiiv && axiiready
axiov  out  1  dibit valid
axiod  out  2  dibit, LSB pair of each byte first
tx_busy  out  1  high in every state except IDLE
tx_err  out  1  one-cycle pulse on underrun or oversize abort

Behaviour:
- Reset: asynchronous on rst_n low; axiov=0, axiod=0, axiiready=0, tx_busy=0, tx_err=0; state IDLE; CRC=0xFFFFFFFF. Mid-frame reset drops axiov immediately and loses the frame.
- States: IDLE -> PREAMBLE -> SFD -> PAYLOAD -> (PAD) -> FCS -> IFG -> IDLE.
- Counters: dibit index d (0..3, 2 bits); byte counter (11 bits, saturating at MAX_FRAME_BYTES+1).
- IDLE:
  - axiiready=0.
  - axiiv=1 at edge N moves to PREAMBLE; axiov=1 from cycle N+1.
- PREAMBLE: 4*PREAMBLE_BYTES cycles of axiod=2'b01.
- SFD (0xD5): dibits 01,01,01,11.
  - axiiready=1 in the d=3 cycle.
  - If axiiv=0 in that cycle: underrun.
- PAYLOAD:
  - The held byte is sent as axiod = byte[1:0], [3:2], [5:4], [7:6] on d=0..3.
  - Every transmitted dibit updates the CRC (reflected poly 0xEDB88320, 2 bits/cycle).
  - axiiready=1 only at d=3, and only if axiilast has not been accepted.
- Underrun: axiiready=1 with axiiv=0 in SFD/PAYLOAD.
  - tx_err pulses, axiov drops next cycle, no FCS is sent.
  - Go to IFG; the receiver sees a truncated frame.
- Oversize: accepting a byte when byte count = MAX_FRAME_BYTES without axiilast takes the same abort path.
- After the last byte's d=3:
  - Go to PAD if bytes sent < MIN_FRAME_BYTES, else FCS.
- PAD: send 0x00 bytes, CRC-included, until the count reaches MIN_FRAME_BYTES.
- FCS:
  - Send ~CRC, 16 dibits, bit 0 first; bytes appear LSB-byte first.
  - CRC is not updated during FCS.
- IFG:
  - axiov=0, axiod=0 for 4*IFG_BYTES cycles.
  - axiiv is ignored; CRC re-initialises on entry.
- axiov is continuous high from the first preamble dibit to the last FCS dibit; no gaps.
- Total frame length: 4*(PREAMBLE_BYTES+1+max(n,MIN)+4) valid cycles for n payload bytes.
- Simultaneous events:
  - axiilast with byte count = MAX_FRAME_BYTES is legal and not an error.
  - An axiiv assertion in IFG is held off; the frame starts from IDLE on the first cycle axiiv is seen there.

Decomposition:
- Shared package eth_pkg:
  - state enum tx_state_t.
  - constants ETH_PREAMBLE=8'h55, ETH_SFD=8'hD5, CRC32_POLY=32'hEDB88320, CRC32_INIT=32'hFFFFFFFF.
- Sub-module crc32_dibit:
  - ports: clk, rst_n, clear, en, dibit[1:0], crc[31:0].
  - combinational 2-bit step, registered state.
  - reused by the firewall's FCS check.

Test Plan:
- Reset then single start, 60 bytes of 0xFF: axiov rises 1 cycle after axiiv; first 28 dibits = 01; SFD dibits 01,01,01,11; 240 payload dibits = 11; 16 FCS dibits; then 48 cycles axiov=0.
- MIN_FRAME_BYTES=0, payload ASCII "123456789": FCS bytes on the wire 0x26,0x39,0xF4,0xCB (CRC 0xCBF43926), first FCS dibit = 2'b10.
- 14-byte frame, last asserted on byte 14: 46 zero bytes padded (184 dibits 00), frame count 60, FCS correct over padded data.
- Underrun, axiiv dropped for byte 5 while axiiready=1: tx_err one-cycle pulse; axiov low next cycle; no FCS; tx_busy high through 48 IFG cycles.
- MAX_FRAME_BYTES=64, 65 bytes without last: tx_err at 65th handshake; frame aborted; last at byte 64 instead gives normal FCS.
- rst_n pulsed low mid-payload: axiov, axiiready, tx_busy go to 0 without a clk edge; the next start produces a full, correct frame.

Source files
------------

// File: rtl/eth_pkg.sv
// Shared definitions for the RMII-style dibit transmit/receive paths.
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_PAYLOAD,
        ST_PAD,
        ST_FCS,
        ST_IFG
    } tx_state_t;

    localparam logic [7:0]  ETH_PREAMBLE = 8'h55;
    localparam logic [7:0]  ETH_SFD      = 8'hD5;
    localparam logic [31:0] CRC32_POLY   = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT   = 32'hFFFFFFFF;

    // One reflected CRC-32 step for a single input bit.
    function automatic logic [31:0] crc32_bit(input logic [31:0] crc_in, input logic b);
        if (crc_in[0] ^ b)
            return (crc_in >> 1) ^ CRC32_POLY;
        else
            return crc_in >> 1;
    endfunction

    // Two bits per call, bit 0 of the dibit first (wire order).
    function automatic logic [31:0] crc32_step2(input logic [31:0] crc_in, input logic [1:0] dibit);
        return crc32_bit(crc32_bit(crc_in, dibit[0]), dibit[1]);
    endfunction

    // Dibit i of a byte, least significant pair first.
    function automatic logic [1:0] sel_dibit(input logic [7:0] b, input logic [1:0] i);
        logic [7:0] s;
        s = b >> {i, 1'b0};
        return s[1:0];
    endfunction

endpackage

// File: rtl/crc32_dibit.sv
// Ethernet CRC-32 accumulator consuming one dibit per enabled cycle.
module crc32_dibit
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        en,
    input  logic [1:0]  dibit,
    output logic [31:0] crc
);

    // CRC state register; clear wins over en.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            crc <= CRC32_INIT;
        else if (clear)
            crc <= CRC32_INIT;
        else if (en)
            crc <= crc32_step2(crc, dibit);
    end

endmodule

// File: rtl/eth_rmii_tx.sv
// Byte-stream to dibit Ethernet framer: preamble/SFD, pad, FCS, inter-frame gap.
module eth_rmii_tx
    import eth_pkg::*;
#(
    parameter int unsigned PREAMBLE_BYTES  = 7,
    parameter int unsigned MIN_FRAME_BYTES = 60,
    parameter int unsigned MAX_FRAME_BYTES = 1514,
    parameter int unsigned IFG_BYTES       = 12
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       axiiv,
    input  logic [7:0] axiid,
    input  logic       axiilast,
    output logic       axiiready,
    output logic       axiov,
    output logic [1:0] axiod,
    output logic       tx_busy,
    output logic       tx_err
);

    localparam logic [10:0] PRE_LAST = 11'(PREAMBLE_BYTES - 1);
    localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME_BYTES);
    localparam logic [10:0] MAX_CNT  = 11'(MAX_FRAME_BYTES);
    localparam logic [10:0] SAT_CNT  = 11'(MAX_FRAME_BYTES + 1);
    localparam logic [10:0] IFG_LAST = 11'(IFG_BYTES - 1);

    tx_state_t   state, state_n;
    logic [1:0]  d, d_n;
    logic [10:0] cnt, cnt_n, cnt_inc;
    logic [7:0]  hold, hold_n;
    logic        last_seen, last_n;
    logic        crc_en, crc_clear;
    logic [31:0] crc, fcs, fcs_sh;

    // cnt doubles as preamble-byte, payload-byte, FCS-byte and IFG-byte counter.
    assign cnt_inc = (cnt == SAT_CNT) ? cnt : cnt + 11'd1;
    assign fcs     = ~crc;
    assign fcs_sh  = fcs >> {cnt[1:0], d, 1'b0};

    crc32_dibit u_crc (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (crc_clear),
        .en    (crc_en),
        .dibit (axiod),
        .crc   (crc)
    );

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            d         <= '0;
            cnt       <= '0;
            hold      <= '0;
            last_seen <= 1'b0;
        end else begin
            state     <= state_n;
            d         <= d_n;
            cnt       <= cnt_n;
            hold      <= hold_n;
            last_seen <= last_n;
        end
    end

    // Next-state, handshake and dibit output decode; all transitions land on d=3.
    always_comb begin
        state_n   = state;
        d_n       = d + 2'd1;
        cnt_n     = cnt;
        hold_n    = hold;
        last_n    = last_seen;
        axiov     = 1'b0;
        axiod     = '0;
        axiiready = 1'b0;
        tx_busy   = (state != ST_IDLE);
        tx_err    = 1'b0;
        crc_en    = 1'b0;
        crc_clear = 1'b0;
        case (state)
            ST_IDLE: begin
                d_n   = '0;
                cnt_n = '0;
                if (axiiv) state_n = ST_PREAMBLE;
            end
            ST_PREAMBLE: begin
                axiov = 1'b1;
                axiod = sel_dibit(ETH_PREAMBLE, d);
                if (d == 2'd3) begin
                    if (cnt == PRE_LAST) begin
                        state_n = ST_SFD;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 11'd1;
                    end
                end
            end
            ST_SFD: begin
                axiov = 1'b1;
                axiod = sel_dibit(ETH_SFD, d);
                if (d == 2'd3) begin
                    axiiready = 1'b1;
                    if (axiiv) begin
                        hold_n  = axiid;
                        last_n  = axiilast;
                        cnt_n   = 11'd1;
                        state_n = ST_PAYLOAD;
                    end else begin
                        tx_err  = 1'b1;
                        cnt_n   = '0;
                        state_n = ST_IFG;
                    end
                end
            end
            ST_PAYLOAD: begin
                axiov  = 1'b1;
                axiod  = sel_dibit(hold, d);
                crc_en = 1'b1;
                if (d == 2'd3) begin
                    if (last_seen) begin
                        if (cnt < MIN_CNT) begin
                            state_n = ST_PAD;
                        end else begin
                            state_n = ST_FCS;
                            cnt_n   = '0;
                        end
                    end else begin
                        axiiready = 1'b1;
                        // Underrun and oversize share one abort path into IFG.
                        if (!axiiv || cnt == MAX_CNT) begin
                            tx_err  = 1'b1;
                            cnt_n   = '0;
                            state_n = ST_IFG;
                        end else begin
                            hold_n = axiid;
                            last_n = axiilast;
                            cnt_n  = cnt_inc;
                        end
                    end
                end
            end
            ST_PAD: begin
                axiov  = 1'b1;
                crc_en = 1'b1;
                if (d == 2'd3) begin
                    if (cnt_inc >= MIN_CNT) begin
                        state_n = ST_FCS;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt_inc;
                    end
                end
            end
            ST_FCS: begin
                axiov = 1'b1;
                axiod = fcs_sh[1:0];
                if (d == 2'd3) begin
                    if (cnt[1:0] == 2'd3) begin
                        state_n = ST_IFG;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 11'd1;
                    end
                end
            end
            ST_IFG: begin
                crc_clear = 1'b1;
                if (d == 2'd3) begin
                    if (cnt == IFG_LAST) begin
                        state_n = ST_IDLE;
                        cnt_n   = '0;
                    end else begin
                        cnt_n = cnt + 11'd1;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_eth_rmii_tx.sv
// Directed bench for eth_rmii_tx: default instance plus a MIN=0/MAX=64 instance.
module tb_eth_rmii_tx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       axiiv = 1'b0;
    logic [7:0] axiid = '0;
    logic       axiilast = 1'b0;
    logic       sel = 1'b0;

    logic       v0, v1, r0, r1, b0, b1, e0, e1;
    logic [1:0] d0, d1;
    logic       o_v, o_ready, o_busy, o_err;
    logic [1:0] o_d;

    always #5 clk = ~clk;

    eth_rmii_tx u_dut (
        .clk(clk), .rst_n(rst_n), .axiiv(axiiv & ~sel), .axiid(axiid), .axiilast(axiilast),
        .axiiready(r0), .axiov(v0), .axiod(d0), .tx_busy(b0), .tx_err(e0)
    );

    eth_rmii_tx #(.MIN_FRAME_BYTES(0), .MAX_FRAME_BYTES(64)) u_dut_small (
        .clk(clk), .rst_n(rst_n), .axiiv(axiiv & sel), .axiid(axiid), .axiilast(axiilast),
        .axiiready(r1), .axiov(v1), .axiod(d1), .tx_busy(b1), .tx_err(e1)
    );

    assign o_v     = sel ? v1 : v0;
    assign o_d     = sel ? d1 : d0;
    assign o_ready = sel ? r1 : r0;
    assign o_busy  = sel ? b1 : b0;
    assign o_err   = sel ? e1 : e0;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    logic [7:0] pl[$];
    logic [1:0] q[$];
    logic [1:0] exp_q[$];
    int first_v_k, last_v_k, err_cnt, err_k, ifg_cycles, segs, hs_cnt;
    logic frame_done;
    logic [31:0] model_fcs;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    // Drive one frame from pl and record the dibit stream; drop_at<0 means no underrun.
    task automatic run_frame(input int drop_at, input bit with_last, input int limit, input bit need_end);
        int idx;
        int n;
        logic prev_v;
        logic seen;
        logic hs;
        n = pl.size();
        q.delete();
        first_v_k = -1; last_v_k = -1; err_cnt = 0; err_k = -1;
        ifg_cycles = 0; segs = 0; hs_cnt = 0; frame_done = 1'b0;
        idx = 0; prev_v = 1'b0; seen = 1'b0;
        @(posedge clk); #1;
        axiid    = pl[0];
        axiilast = with_last && (n == 1);
        axiiv    = (drop_at != 0);
        for (int k = 0; k < limit && !frame_done; k++) begin
            @(negedge clk);
            if (o_v) begin
                q.push_back(o_d);
                if (!seen) first_v_k = k;
                if (!prev_v) segs++;
                seen = 1'b1;
                last_v_k = k;
            end
            if (o_err) begin
                err_cnt++;
                err_k = k;
            end
            if (seen && !o_v && o_busy) ifg_cycles++;
            if (seen && !o_busy) frame_done = 1'b1;
            hs = o_ready && axiiv;
            prev_v = o_v;
            @(posedge clk); #1;
            if (hs) begin
                idx++;
                hs_cnt++;
            end
            if (idx < n) begin
                axiid    = pl[idx];
                axiilast = with_last && (idx == n - 1);
                axiiv    = (idx != drop_at);
            end else begin
                axiiv    = 1'b0;
                axiilast = 1'b0;
            end
        end
        axiiv    = 1'b0;
        axiilast = 1'b0;
        if (need_end) chk("frame_end", {31'd0, frame_done}, 32'd1);
    endtask

    // Expected wire stream from the payload, with zero padding to min_bytes.
    task automatic build_exp(input int min_bytes);
        logic [31:0] c;
        logic [31:0] t32;
        logic [7:0]  b;
        logic [7:0]  t;
        logic [7:0]  sfd;
        int nb;
        exp_q.delete();
        sfd = 8'hD5;
        for (int i = 0; i < 28; i++) exp_q.push_back(2'b01);
        for (int i = 0; i < 4; i++) begin
            t = sfd >> (2 * i);
            exp_q.push_back(t[1:0]);
        end
        nb = (pl.size() > min_bytes) ? pl.size() : min_bytes;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < nb; i++) begin
            b = (i < pl.size()) ? pl[i] : 8'h00;
            for (int j = 0; j < 4; j++) begin
                t = b >> (2 * j);
                exp_q.push_back(t[1:0]);
            end
            c = c ^ {24'd0, b};
            for (int j = 0; j < 8; j++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        model_fcs = ~c;
        for (int i = 0; i < 16; i++) begin
            t32 = model_fcs >> (2 * i);
            exp_q.push_back(t32[1:0]);
        end
    endtask

    task automatic cmp_stream(input string tag);
        int mism;
        int n;
        mism = 0;
        n = (q.size() < exp_q.size()) ? q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            if (q[i] !== exp_q[i]) mism++;
        chk(tag, mism, 0);
    endtask

    function automatic logic [31:0] rx_fcs();
        logic [31:0] f;
        f = '0;
        if (q.size() >= 16)
            for (int i = 0; i < 16; i++)
                f = f | ({30'd0, q[q.size() - 16 + i]} << (2 * i));
        return f;
    endfunction

    initial begin
        int nz;
        string s;

        // Reset state
        sel = 1'b0;
        #2;
        chk("rst_axiov", {31'd0, o_v}, 32'd0);
        chk("rst_axiod", {30'd0, o_d}, 32'd0);
        chk("rst_ready", {31'd0, o_ready}, 32'd0);
        chk("rst_busy", {31'd0, o_busy}, 32'd0);
        chk("rst_err", {31'd0, o_err}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // 60 bytes of 0xFF
        pl.delete();
        for (int i = 0; i < 60; i++) pl.push_back(8'hFF);
        run_frame(-1, 1'b1, 2000, 1'b1);
        build_exp(60);
        chk("ff_first_valid", first_v_k, 1);
        chk("ff_len", q.size(), 288);
        chk("ff_sfd_last", {30'd0, q[31]}, 32'd3);
        chk("ff_payload0", {30'd0, q[32]}, 32'd3);
        cmp_stream("ff_stream");
        chk("ff_fcs", rx_fcs(), model_fcs);
        chk("ff_ifg", ifg_cycles, 48);
        chk("ff_segs", segs, 1);
        chk("ff_err", err_cnt, 0);

        // MIN=0 instance, "123456789"
        sel = 1'b1;
        s = "123456789";
        pl.delete();
        for (int i = 0; i < 9; i++) pl.push_back(s[i]);
        run_frame(-1, 1'b1, 2000, 1'b1);
        build_exp(0);
        chk("chk9_len", q.size(), 84);
        chk("chk9_fcs", rx_fcs(), 32'hCBF43926);
        chk("chk9_fcs_d0", {30'd0, q[68]}, 32'd2);
        cmp_stream("chk9_stream");

        // 14-byte frame padded to 60
        sel = 1'b0;
        pl.delete();
        for (int i = 0; i < 14; i++) pl.push_back(8'(8'h11 * (i + 1)));
        run_frame(-1, 1'b1, 2000, 1'b1);
        build_exp(60);
        chk("pad_len", q.size(), 288);
        nz = 0;
        for (int i = 32 + 56; i < 32 + 56 + 184; i++)
            if (q[i] !== 2'b00) nz++;
        chk("pad_zero_dibits", nz, 0);
        chk("pad_fcs", rx_fcs(), model_fcs);
        cmp_stream("pad_stream");

        // Underrun on byte 5
        pl.delete();
        for (int i = 0; i < 20; i++) pl.push_back(8'(8'hA0 + i));
        run_frame(4, 1'b1, 2000, 1'b1);
        build_exp(60);
        chk("urun_err_cnt", err_cnt, 1);
        chk("urun_err_at_last", err_k, last_v_k);
        chk("urun_len", q.size(), 48);
        chk("urun_ifg", ifg_cycles, 48);
        chk("urun_segs", segs, 1);
        cmp_stream("urun_stream");

        // MAX=64 instance, 65 bytes without last
        sel = 1'b1;
        pl.delete();
        for (int i = 0; i < 65; i++) pl.push_back(8'(i * 3 + 1));
        run_frame(-1, 1'b0, 2000, 1'b1);
        build_exp(0);
        chk("ovr_err_cnt", err_cnt, 1);
        chk("ovr_err_at_last", err_k, last_v_k);
        chk("ovr_len", q.size(), 288);
        chk("ovr_hs", hs_cnt, 65);
        cmp_stream("ovr_stream");

        // MAX=64 instance, last exactly at byte 64
        pl.delete();
        for (int i = 0; i < 64; i++) pl.push_back(8'(i * 3 + 1));
        run_frame(-1, 1'b1, 2000, 1'b1);
        build_exp(0);
        chk("max_err_cnt", err_cnt, 0);
        chk("max_len", q.size(), 304);
        chk("max_fcs", rx_fcs(), model_fcs);
        cmp_stream("max_stream");

        // Asynchronous reset mid-payload, then a full frame
        sel = 1'b0;
        pl.delete();
        for (int i = 0; i < 60; i++) pl.push_back(8'(8'h5A ^ i));
        run_frame(-1, 1'b1, 100, 1'b0);
        @(negedge clk);
        chk("mid_pre_axiov", {31'd0, o_v}, 32'd1);
        chk("mid_pre_busy", {31'd0, o_busy}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_axiov", {31'd0, o_v}, 32'd0);
        chk("mid_rst_ready", {31'd0, o_ready}, 32'd0);
        chk("mid_rst_busy", {31'd0, o_busy}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame(-1, 1'b1, 2000, 1'b1);
        build_exp(60);
        chk("post_rst_len", q.size(), 288);
        chk("post_rst_fcs", rx_fcs(), model_fcs);
        cmp_stream("post_rst_stream");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
